f_pc_fetch: RTL
===============

// Module: f_pc_fetch
// PURPOSE
//   Fetch-stage PC unit of the P7 pipeline. Holds the architectural fetch PC
//   and selects the next PC from: exception entry, ERET return, D-stage
//   branch/jump redirect, or sequential PC+4.
//   Presents the fetch address and instruction to the IF/ID register, with
//   delay-slot (BD) and fetch-address-error (AdEL) tags.
//   Sits between instruction memory and the D-stage pipeline register.
// PARAMETERS
//   PC_RESET   32'h0000_3000  PC value after reset
//   EXC_ENTRY  32'h0000_4180  handler entry, loaded when Req=1
//   IM_BASE    32'h0000_3000  lowest legal fetch address
//   IM_END     32'h0000_6ffc  highest legal fetch address
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   En           in   1   stall: 1 = hold PC (same sense as D stage)
//   Req          in   1   exception/interrupt request from CP0
//   eret_D       in   1   ERET is in D stage
//   EPC          in   32  return address from CP0
//   jump_D       in   1   branch taken / jump in D stage
//   NPC_D        in   32  redirect target from D stage
//   is_bj_D      in   1   instruction in D is a branch/jump (any outcome)
//   instr_IM     in   32  instruction word read from IM at WPC_F
//   WPC_F        out  32  current fetch PC, also the IM address
//   instr_F      out  32  instruction forwarded to D stage
//   BD_F         out  1   fetched instruction is in a delay slot
//   AdEL_sign_pc out  1   fetch address error
//   fetch_cnt    out  32  count of instructions advanced out of F (debug)
// BEHAVIOUR
//   - reset=0 (async): PC<=PC_RESET, fetch_cnt<=0.
//     Outputs settle from these values; reset overrides all other inputs.
//   - Next-PC priority at each posedge, highest first:
//       Req=1              -> PC<=EXC_ENTRY (ignores En, matches D-stage flush)
//       En=1               -> PC holds
//       eret_D=1           -> PC<=EPC
//       jump_D=1           -> PC<=NPC_D
//       else               -> PC<=PC+4 (32-bit wrap, no saturation)
//   - Combinational outputs:
//       WPC_F = PC
//       AdEL_sign_pc = (PC[1:0]!=0) | (PC<IM_BASE) | (PC>IM_END)
//       squash = eret_D & ~Req
//                (the fetch after ERET is not executed; ERET has no delay slot)
//       instr_F = (AdEL_sign_pc | squash) ? 32'h0 : instr_IM
//       BD_F = is_bj_D & ~squash
//   - With AdEL=1, D stage records ExcCode 4; F still forwards WPC_F unchanged
//     so EPC captures the bad address.
//   - fetch_cnt increments by 1 on posedge when reset=1, Req=0, En=0.
//     Squashed fetches are also counted. Wraps at 2^32.
//   - Req and eret_D together: Req wins, and squash is 0.
//   - En=1 together with jump_D=1: the redirect is not lost. D holds the
//     branch, so jump_D persists to the first unstalled cycle.
//   - Reset mid-run: PC returns to PC_RESET immediately, without waiting
//     for a clock edge.
// TESTING
//   1. Reset low 2 cycles, then release
//      -> WPC_F=0x3000, then 0x3004, 0x3008; fetch_cnt=1,2.
//   2. En=1 for 3 cycles at 0x3008
//      -> WPC_F stays 0x3008, fetch_cnt frozen; releases to 0x300c.
//   3. jump_D=1, NPC_D=0x3100, is_bj_D=1 at PC 0x3010
//      -> BD_F=1 that cycle; next WPC_F=0x3100.
//   4. Req=1 with En=1 at PC 0x3020
//      -> next WPC_F=0x4180; stall ignored.
//   5. eret_D=1, EPC=0x3024, instr_IM=0x24010001
//      -> instr_F=0 and BD_F=0 that cycle; next WPC_F=0x3024.
//   6. jump_D to NPC_D=0x3002, then to 0x7000
//      -> AdEL_sign_pc=1 and instr_F=0 in each case.
//      Async reset asserted between edges -> WPC_F=0x3000 at once.

Source files
------------

// File: rtl/f_pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : f_pc_fetch_if
// Brief    : Signal bundle between the fetch PC unit, IM and the D stage.
// Revision : 1.0 - initial release
// ============================================================================
interface f_pc_fetch_if;
    logic        En;
    logic        Req;
    logic        eret_D;
    logic [31:0] EPC;
    logic        jump_D;
    logic [31:0] NPC_D;
    logic        is_bj_D;
    logic [31:0] instr_IM;
    logic [31:0] WPC_F;
    logic [31:0] instr_F;
    logic        BD_F;
    logic        AdEL_sign_pc;
    logic [31:0] fetch_cnt;

    // Environment side: drives control/redirects and IM data, consumes fetch results.
    modport master (
        output En, Req, eret_D, EPC, jump_D, NPC_D, is_bj_D, instr_IM,
        input  WPC_F, instr_F, BD_F, AdEL_sign_pc, fetch_cnt
    );

    modport slave (
        input  En, Req, eret_D, EPC, jump_D, NPC_D, is_bj_D, instr_IM,
        output WPC_F, instr_F, BD_F, AdEL_sign_pc, fetch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/f_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : f_pc_fetch
// Brief    : Fetch-stage PC register, next-PC selection and IF/ID tagging.
// Revision : 1.0 - initial release
// ============================================================================
module f_pc_fetch #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_END    = 32'h0000_6ffc
) (
    input  wire logic     clk,
    input  wire logic     reset,
    f_pc_fetch_if.slave   fif
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic        w_adel;
    logic        w_squash;

    // Exception entry overrides a stall so F stays in step with the D-stage flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else if (fif.Req) begin
            r_pc <= EXC_ENTRY;
        end else if (!fif.En) begin
            if (fif.eret_D)
                r_pc <= fif.EPC;
            else if (fif.jump_D)
                r_pc <= fif.NPC_D;
            else
                r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_fetch_cnt <= 32'd0;
        else if (!fif.Req && !fif.En)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end

    always_comb begin
        w_adel   = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_END);
        // ERET has no delay slot, so the word fetched behind it is discarded.
        w_squash = fif.eret_D && !fif.Req;
    end

    assign fif.WPC_F        = r_pc;
    assign fif.AdEL_sign_pc = w_adel;
    assign fif.instr_F      = (w_adel || w_squash) ? 32'h0 : fif.instr_IM;
    assign fif.BD_F         = fif.is_bj_D && !w_squash;
    assign fif.fetch_cnt    = r_fetch_cnt;

endmodule
`default_nettype wire
